dcache_ctrl: RTL and testbench

Miss-handling controller for the 2-way, 1 KB, 16-byte-block write-back data cache. It sits between the CPU load/store port and the data-cache SRAM array.
- Hits are served combinationally in one cycle.
- Misses run a write-back/refill sequence against main memory: evict dirty victim, fetch block, install, retry.
- It also keeps saturating hit/miss/write-back statistics.

---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_stats.sv | 32 +++
 rtl/dcache_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry, FSM state encoding and block/word helpers
// for the 2-way, 16-byte-block write-back data cache controller.
package dcache_pkg;

  localparam int DC_BLOCK_BYTES = 16;
  localparam int DC_SETS        = 32;
  localparam int DC_OFF_W       = $clog2(DC_BLOCK_BYTES);
  localparam int DC_IDX_W       = $clog2(DC_SETS);
  localparam int DC_TAG_W       = 32 - DC_OFF_W - DC_IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WB,
    ST_REFILL,
    ST_INSTALL
  } state_t;

  // Pick 32-bit word w out of a 128-bit block.
  function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] w);
    return blk[{w, 5'b0} +: 32];
  endfunction

  // Move a word's 4 byte enables to its lane in the 16-byte block.
  function automatic logic [15:0] be_expand(input logic [3:0] be, input logic [1:0] w);
    return {12'b0, be} << {w, 2'b00};
  endfunction

endpackage

// File: rtl/dcache_stats.sv
// dcache_stats: three saturating event counters (hit, miss, write-back).
// Ports: clk, rst (async active-low), *_inc strobes in, *_cnt counts out.
module dcache_stats #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit_inc,
  input  logic             miss_inc,
  input  logic             wb_inc,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  logic [2:0]            inc;
  logic [2:0][CNT_W-1:0] cnt;

  assign inc = {wb_inc, miss_inc, hit_inc};

  for (genvar i = 0; i < 3; i++) begin : g_cnt
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                    cnt[i] <= '0;
      else if (inc[i] && ~&cnt[i]) cnt[i] <= cnt[i] + 1'b1;  // hold at all-ones
    end
  end

  assign hit_cnt  = cnt[0];
  assign miss_cnt = cnt[1];
  assign wb_cnt   = cnt[2];

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: miss-handling controller for a 2-way write-back data cache.
// Hits complete combinationally; misses run WB (dirty victim) -> REFILL ->
// INSTALL, then the held CPU request retries and hits.
// Ports: CPU load/store port (cpu_*), cache SRAM controls and lookup results
// (sram_*), block-wide memory port (mem_*), saturating statistics (*_cnt).
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int BLOCK_BYTES = DC_BLOCK_BYTES,
  parameter int SETS        = DC_SETS,
  parameter int CNT_W       = 32,
  localparam int OFF_W      = $clog2(BLOCK_BYTES),
  localparam int IDX_W      = $clog2(SETS),
  localparam int TAG_W      = ADDR_W - OFF_W - IDX_W,
  localparam int BA_W       = ADDR_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_be,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              sram_en,
  output logic              sram_wen,
  output logic              sram_memWen,
  output logic [15:0]       sram_bytesAccess,
  output logic [BA_W-1:0]   sram_blockAddr,
  output logic [127:0]      sram_dataIn,
  input  logic              sram_hit,
  input  logic              sram_dirty,
  input  logic [127:0]      sram_dataOut,
  input  logic [TAG_W-1:0]  sram_victim_tag,
  input  logic [127:0]      sram_victim_data,
  output logic              mem_req,
  output logic              mem_wen,
  output logic [BA_W-1:0]   mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic [127:0]      mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  wb_cnt
);

  state_t             state, state_nxt;
  logic [TAG_W-1:0]   vic_tag;
  logic [127:0]       vic_data;
  logic [127:0]       refill_buf;
  logic [BA_W-1:0]    blk_addr;
  logic               look, hit, miss;
  logic [1:0]         wsel;
  logic               unused_addr;

  assign look        = (state == ST_IDLE) && cpu_req;
  assign hit         = look && sram_hit;
  assign miss        = look && !sram_hit;
  assign wsel        = cpu_addr[OFF_W-1:2];
  assign unused_addr = ^cpu_addr[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (miss) state_nxt = sram_dirty ? ST_WB : ST_REFILL;
      ST_WB:      if (mem_ready) state_nxt = ST_REFILL;
      ST_REFILL:  if (mem_ready) state_nxt = ST_INSTALL;
      ST_INSTALL: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Victim and target are captured on the detect cycle so the memory
  // sequence does not depend on the CPU holding its inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vic_tag    <= '0;
      vic_data   <= '0;
      blk_addr   <= '0;
      refill_buf <= '0;
    end else begin
      if (miss) begin
        vic_tag  <= sram_victim_tag;
        vic_data <= sram_victim_data;
        blk_addr <= cpu_addr[ADDR_W-1:OFF_W];
      end
      if (state == ST_REFILL && mem_ready) refill_buf <= mem_rdata;
    end
  end

  always_comb begin
    cpu_rdata        = '0;
    cpu_stall        = 1'b0;
    sram_en          = 1'b0;
    sram_wen         = 1'b0;
    sram_memWen      = 1'b0;
    sram_bytesAccess = '0;
    sram_blockAddr   = '0;
    sram_dataIn      = '0;
    mem_req          = 1'b0;
    mem_wen          = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    unique case (state)
      ST_IDLE: begin
        if (cpu_req) begin
          sram_en        = 1'b1;
          sram_blockAddr = cpu_addr[ADDR_W-1:OFF_W];
          if (sram_hit) begin
            cpu_rdata = word_sel(sram_dataOut, wsel);
            if (cpu_wen) begin
              sram_wen         = 1'b1;
              sram_dataIn      = {4{cpu_wdata}};
              sram_bytesAccess = be_expand(cpu_be, wsel);
            end
          end else begin
            cpu_stall = 1'b1;
          end
        end
      end
      ST_WB: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_wen   = 1'b1;
        mem_addr  = {vic_tag, blk_addr[IDX_W-1:0]};
        mem_wdata = vic_data;
      end
      ST_REFILL: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = blk_addr;
      end
      ST_INSTALL: begin
        cpu_stall        = 1'b1;
        sram_en          = 1'b1;
        sram_wen         = 1'b1;
        sram_memWen      = 1'b1;
        sram_blockAddr   = blk_addr;
        sram_dataIn      = refill_buf;
        sram_bytesAccess = 16'hFFFF;
      end
      default: ;
    endcase
  end

  dcache_stats #(.CNT_W(CNT_W)) u_stats (
    .clk      (clk),
    .rst      (rst),
    .hit_inc  (hit),
    .miss_inc (miss),
    .wb_inc   (state == ST_WB && mem_ready),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .wb_cnt   (wb_cnt)
  );

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: bench for dcache_ctrl with a behavioural 2-way PLRU SRAM,
// a latency-programmable block memory, and a load-data scoreboard.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req, cpu_wen;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]   cpu_be;
  logic         cpu_stall;
  logic         sram_en, sram_wen, sram_memWen;
  logic [15:0]  sram_bytesAccess;
  logic [27:0]  sram_blockAddr;
  logic [127:0] sram_dataIn, sram_dataOut, sram_victim_data;
  logic         sram_hit, sram_dirty;
  logic [22:0]  sram_victim_tag;
  logic         mem_req, mem_wen, mem_ready;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic [5:0]   hit_cnt, miss_cnt, wb_cnt;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  dcache_ctrl #(.CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_memWen(sram_memWen),
    .sram_bytesAccess(sram_bytesAccess), .sram_blockAddr(sram_blockAddr),
    .sram_dataIn(sram_dataIn), .sram_hit(sram_hit), .sram_dirty(sram_dirty),
    .sram_dataOut(sram_dataOut), .sram_victim_tag(sram_victim_tag),
    .sram_victim_data(sram_victim_data),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  // ---------------- reference memory contents ----------------
  function automatic logic [31:0] init_word(input logic [27:0] ba, input logic [1:0] w);
    logic [3:0] nib;
    nib = 4'hA + {2'b00, w};
    if (ba == 28'h10) return {8{nib}};
    return {ba[19:0], 10'h2A5, w};
  endfunction

  logic [127:0] bmem[int];   // backing memory blocks that were written back
  logic [31:0]  ref_w[int];  // architectural word values after stores
  logic [31:0]  exp_q[$];

  function automatic logic [127:0] mem_block(input logic [27:0] ba);
    logic [127:0] b;
    if (bmem.exists(int'(ba))) return bmem[int'(ba)];
    for (int w = 0; w < 4; w++) b[32*w +: 32] = init_word(ba, w[1:0]);
    return b;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_w.exists(int'(a[31:2]))) return ref_w[int'(a[31:2])];
    return init_word(a[31:4], a[3:2]);
  endfunction

  // ---------------- behavioural 2-way SRAM ----------------
  logic [22:0]  m_tag [32][2] = '{default: '{default: '0}};
  logic         m_v   [32][2] = '{default: '{default: 1'b0}};
  logic         m_d   [32][2] = '{default: '{default: 1'b0}};
  logic [127:0] m_data[32][2] = '{default: '{default: '0}};
  logic         m_lru [32]    = '{default: 1'b0};   // way to evict next
  logic [4:0]   s_set;
  logic [22:0]  s_tag;
  logic         s_hw, s_vw;
  logic [127:0] s_merged;

  always_comb begin
    s_set   = sram_blockAddr[4:0];
    s_tag   = sram_blockAddr[27:5];
    sram_hit = 1'b0;
    s_hw     = 1'b0;
    for (int w = 0; w < 2; w++)
      if (m_v[s_set][w] && m_tag[s_set][w] == s_tag) begin
        sram_hit = 1'b1;
        s_hw     = w[0];
      end
    s_vw = !m_v[s_set][0] ? 1'b0 : !m_v[s_set][1] ? 1'b1 : m_lru[s_set];
    sram_dataOut     = sram_hit ? m_data[s_set][s_hw] : '0;
    sram_dirty       = m_v[s_set][s_vw] & m_d[s_set][s_vw];
    sram_victim_tag  = m_tag[s_set][s_vw];
    sram_victim_data = m_data[s_set][s_vw];
    s_merged = m_data[s_set][s_hw];
    for (int b = 0; b < 16; b++)
      if (sram_bytesAccess[b]) s_merged[8*b +: 8] = sram_dataIn[8*b +: 8];
  end

  always @(posedge clk) begin
    if (sram_en && sram_wen && sram_memWen) begin
      m_tag[s_set][s_vw]  <= s_tag;
      m_v[s_set][s_vw]    <= 1'b1;
      m_d[s_set][s_vw]    <= 1'b0;
      m_data[s_set][s_vw] <= sram_dataIn;
      m_lru[s_set]        <= ~s_vw;
    end else if (sram_en && sram_wen && sram_hit) begin
      m_data[s_set][s_hw] <= s_merged;
      m_d[s_set][s_hw]    <= 1'b1;
      m_lru[s_set]        <= ~s_hw;
    end else if (sram_en && sram_hit) begin
      m_lru[s_set]        <= ~s_hw;
    end
  end

  // ---------------- memory responder ----------------
  int           mem_lat = 3, mcnt = 0, wb_seen = 0;
  logic [27:0]  wb_addr = '0;
  logic [127:0] wb_data = '0;
  bit           wen_seen = 1'b0;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (mem_req) begin
        if (mem_wen) wen_seen = 1'b1;
        mcnt++;
        if (mcnt >= mem_lat) begin
          mcnt      = 0;
          mem_ready = 1'b1;
          if (mem_wen) begin
            bmem[int'(mem_addr)] = mem_wdata;
            wb_seen++;
            wb_addr = mem_addr;
            wb_data = mem_wdata;
          end else begin
            mem_rdata = mem_block(mem_addr);
          end
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  // One CPU access: held until the stall clears; load data checked against
  // the scoreboard entry pushed at issue.
  task automatic access(input logic wen, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output int stalls, output logic [15:0] bytes);
    logic [31:0] exp, merged;
    stalls = 0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_be = be; cpu_wdata = wd;
    if (!wen) exp_q.push_back(ref_read(addr));
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      stalls++;
      if (stalls > 100) begin
        checks++; failures++;
        $display("FAIL access_timeout addr=%h still stalled after %0d cycles", addr, stalls);
        break;
      end
    end
    bytes = sram_bytesAccess;
    if (!wen) begin
      exp = exp_q.pop_front();
      checks++;
      if (cpu_rdata !== exp) begin
        failures++;
        $display("FAIL load_data addr=%h got=%h exp=%h", addr, cpu_rdata, exp);
      end
    end else begin
      merged = ref_read(addr);
      for (int b = 0; b < 4; b++) if (be[b]) merged[8*b +: 8] = wd[8*b +: 8];
      ref_w[int'(addr[31:2])] = merged;
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", cpu_stall); end
    checks++; if (mem_req !== 1'b0 || mem_wen !== 1'b0) begin failures++; $display("FAIL reset_mem got=%b%b exp=00", mem_req, mem_wen); end
    checks++; if ({sram_en, sram_wen, sram_memWen} !== 3'b0) begin failures++; $display("FAIL reset_sram got=%b exp=000", {sram_en, sram_wen, sram_memWen}); end
    checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin failures++; $display("FAIL reset_memaddr got=%h/%h exp=0", mem_addr, mem_wdata); end
    checks++; if (cpu_rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", cpu_rdata); end
    checks++; if ({hit_cnt, miss_cnt, wb_cnt} !== '0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d/%0d exp=0", hit_cnt, miss_cnt, wb_cnt); end
  endtask

  task automatic test_refill_load();
    int st; logic [15:0] bs;
    mem_lat = 3; wen_seen = 1'b0;
    access(1'b0, 32'h0000_0104, 4'h0, 32'h0, st, bs);
    checks++; if (st != 5) begin failures++; $display("FAIL refill_stalls got=%0d exp=5", st); end
    checks++; if (miss_cnt !== 6'd1 || hit_cnt !== 6'd1) begin failures++; $display("FAIL refill_cnt got=%0d/%0d exp=1/1", miss_cnt, hit_cnt); end
    checks++; if (wen_seen) begin failures++; $display("FAIL refill_wen got=1 exp=0"); end
  endtask

  task automatic test_store_hit();
    int st; logic [15:0] bs;
    access(1'b1, 32'h0000_0108, 4'b0011, 32'h1234_5678, st, bs);
    checks++; if (st != 0) begin failures++; $display("FAIL store_stalls got=%0d exp=0", st); end
    checks++; if (bs !== 16'h0300) begin failures++; $display("FAIL store_bytes got=%h exp=0300", bs); end
    access(1'b0, 32'h0000_0108, 4'h0, 32'h0, st, bs);  // expects CCCC_5678
    checks++; if (st != 0) begin failures++; $display("FAIL store_rd_stalls got=%0d exp=0", st); end
    checks++; if (hit_cnt !== 6'd3) begin failures++; $display("FAIL store_hitcnt got=%0d exp=3", hit_cnt); end
  endtask

  task automatic test_dirty_evict();
    int st; logic [15:0] bs; logic [5:0] m0, w0;
    mem_lat = 3;
    access(1'b0, 32'h0000_0230, 4'h0, 32'h0, st, bs);
    access(1'b0, 32'h0000_0430, 4'h0, 32'h0, st, bs);
    access(1'b1, 32'h0000_0234, 4'hF, 32'hDEAD_BEEF, st, bs);
    access(1'b0, 32'h0000_0430, 4'h0, 32'h0, st, bs);   // tag 1 becomes LRU
    m0 = miss_cnt; w0 = wb_cnt;
    access(1'b0, 32'h0000_0630, 4'h0, 32'h0, st, bs);
    checks++; if (st != 8) begin failures++; $display("FAIL wb_stalls got=%0d exp=8", st); end
    checks++; if (wb_addr !== 28'h23) begin failures++; $display("FAIL wb_addr got=%h exp=0000023", wb_addr); end
    checks++; if (wb_data[63:32] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wb_data got=%h exp=deadbeef", wb_data[63:32]); end
    checks++; if (wb_cnt !== w0 + 6'd1 || miss_cnt !== m0 + 6'd1) begin failures++; $display("FAIL wb_cnt got=%0d/%0d exp=%0d/%0d", wb_cnt, miss_cnt, w0 + 6'd1, m0 + 6'd1); end
  endtask

  task automatic test_clean_victim();
    int st; logic [15:0] bs; logic [5:0] w0;
    w0 = wb_cnt; wen_seen = 1'b0;
    access(1'b0, 32'h0000_0234, 4'h0, 32'h0, st, bs);  // refetches the written-back word
    checks++; if (st != 5) begin failures++; $display("FAIL clean_stalls got=%0d exp=5", st); end
    checks++; if (wen_seen) begin failures++; $display("FAIL clean_wen got=1 exp=0"); end
    checks++; if (wb_cnt !== w0) begin failures++; $display("FAIL clean_wbcnt got=%0d exp=%0d", wb_cnt, w0); end
  endtask

  task automatic test_reset_mid_refill();
    int st; logic [15:0] bs;
    mem_lat = 20;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h0000_0504;
    for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_reach got=%b exp=1", mem_req); end
    @(negedge clk);
    cpu_req = 1'b0; rst = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin failures++; $display("FAIL rstmid_async got=%b%b exp=00", mem_req, cpu_stall); end
    checks++; if (miss_cnt !== 6'd0 || sram_en !== 1'b0) begin failures++; $display("FAIL rstmid_state got=%0d/%b exp=0/0", miss_cnt, sram_en); end
    @(negedge clk); rst = 1'b1; mem_lat = 3;
    access(1'b0, 32'h0000_0504, 4'h0, 32'h0, st, bs);
    checks++; if (st != 5) begin failures++; $display("FAIL rstmid_stalls got=%0d exp=5", st); end
    checks++; if (miss_cnt !== 6'd1 || hit_cnt !== 6'd1) begin failures++; $display("FAIL rstmid_cnt got=%0d/%0d exp=1/1", miss_cnt, hit_cnt); end
  endtask

  task automatic test_saturate();
    int st; logic [15:0] bs;
    for (int i = 0; i < 61; i++) access(1'b0, 32'h0000_0508, 4'h0, 32'h0, st, bs);
    checks++; if (hit_cnt !== 6'd62) begin failures++; $display("FAIL sat_below got=%0d exp=62", hit_cnt); end
    access(1'b0, 32'h0000_050C, 4'h0, 32'h0, st, bs);
    checks++; if (hit_cnt !== 6'd63) begin failures++; $display("FAIL sat_top got=%0d exp=63", hit_cnt); end
    for (int i = 0; i < 3; i++) access(1'b0, 32'h0000_0500, 4'h0, 32'h0, st, bs);
    checks++; if (hit_cnt !== 6'd63 || miss_cnt !== 6'd1) begin failures++; $display("FAIL sat_hold got=%0d/%0d exp=63/1", hit_cnt, miss_cnt); end
  endtask

  initial begin
    rst = 1'b0; cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    test_refill_load();
    test_store_hit();
    test_dirty_evict();
    test_clean_victim();
    test_reset_mid_refill();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
